fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Program-counter and fetch pipeline stage driving the combinational, word-addressed instruction memory in the CPU test harness.
- Holds the PC, presents it as the memory address, and registers the returned 32-bit word into an IF/ID output slot.
- The output slot uses a valid/ready handshake toward decode.
- Supports branch/jump redirect with flush, downstream backpressure, and halt on the end-of-program word; the memory returns all-zero beyond the loaded program.

Parameters:
- ADDR_WIDTH, 16, PC / instruction-memory address width (word index).
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_WORD, 32'h0000_0000, fetched word that ends the program.
- HALT_ENABLE, 1, 1 = HALT_WORD stops fetch; 0 = HALT_WORD is an ordinary instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_addr  out  ADDR_WIDTH  address to instruction memory; equals pc combinationally.
- imem_data  in  DATA_WIDTH  word from instruction memory, valid same cycle as imem_addr.
- redirect_valid  in  1  take redirect_pc this cycle.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- id_valid  out  1  output slot holds an instruction.
- id_ready  in  1  decode accepts the slot this cycle.
- id_instr  out  DATA_WIDTH  registered instruction.
- id_pc  out  ADDR_WIDTH  address id_instr was fetched from.
- halted  out  1  fetch stopped on HALT_WORD.
- fetch_count  out  16  saturating count of completed handshakes.

Behaviour:
- Reset: pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, halted=0, fetch_count=0, state=RUN. Reset overrides every other input, including mid-stall and mid-halt.
- States: RUN, HALT. halted=1 exactly when state=HALT.
- Definitions:
  - fire = id_valid & id_ready (handshake completes).
  - slot_free = ~id_valid | id_ready.
- Priority each cycle (non-reset), highest first:
  1. redirect_valid=1:
     - pc<=redirect_pc, id_valid<=0 (the slot is flushed even if id_ready=1), state<=RUN.
     - No capture this cycle. This also exits HALT.
  2. state=HALT:
     - pc, id_* hold; id_valid<=0 once the pending slot is consumed (fire).
  3. state=RUN and slot_free, with imem_data==HALT_WORD and HALT_ENABLE=1:
     - id_valid<=0, state<=HALT, pc holds at the halt word's address.
     - The halt word is never presented downstream.
  4. state=RUN and slot_free, otherwise:
     - id_instr<=imem_data, id_pc<=pc, id_valid<=1.
     - pc<=pc+1, modulo 2^ADDR_WIDTH: all-ones wraps to 0 with no error.
  5. Otherwise (id_valid=1, id_ready=0): all state holds (stall). imem_addr stays stable.
- Latency: one cycle from pc to id_instr. With id_ready held at 1, one instruction is delivered per cycle and the first id_valid occurs in the first cycle after rst deasserts.
- Stability: while id_valid=1 and id_ready=0, id_instr and id_pc must not change.
- fetch_count:
  - Increments by 1 on fire, including the fire of the last slot when entering HALT. A fire in the same cycle as a redirect still counts.
  - Saturates at 16'hFFFF; never wraps.
- No combinational path from id_ready or redirect_* to id_* outputs. imem_addr depends only on the pc register.

Test Plan:
- Sequential fetch: memory words 1..5 then 0, id_ready=1 -> id_instr 1,2,3,4,5 with id_pc 0..4 on consecutive cycles; halted=1 one cycle after word 5 is captured; fetch_count=5; pc=5.
- Backpressure: id_ready=0 for 3 cycles while id_instr=2 -> id_instr=2 and id_pc=1 are stable, pc=2 holds; on id_ready=1 the next cycle shows id_instr=3; fetch_count counts each instruction once.
- Redirect under stall: id_valid=1, id_ready=0, redirect_valid=1 with redirect_pc=0x0010 -> next cycle id_valid=0 and pc=0x0010; the cycle after, id_pc=0x0010; the flushed instruction is not counted.
- Halt exit: in HALT, redirect_pc=0x0002 -> halted=0 and fetching resumes at word 2; with HALT_ENABLE=0, a zero word is delivered as id_instr=0 and halted stays 0.
- Wrap and reset: redirect to 0xFFFF -> id_pc=0xFFFF then id_pc=0x0000. Asserting rst during a stall -> next cycle id_valid=0, pc=RESET_PC, fetch_count=0, halted=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Program-counter and fetch stage: drives a combinational word-addressed instruction memory
// and registers the returned word into a valid/ready IF/ID slot, with redirect and halt.
module fetch_stage #(
   parameter int unsigned           ADDR_WIDTH  = 16,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [DATA_WIDTH-1:0] HALT_WORD   = '0,
   parameter bit                    HALT_ENABLE = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  id_valid,
   input  logic                  id_ready,
   output logic [DATA_WIDTH-1:0] id_instr,
   output logic [ADDR_WIDTH-1:0] id_pc,
   output logic                  halted,
   output logic [15:0]           fetch_count
);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic                    valid_q, valid_d;
   logic [DATA_WIDTH-1:0]   instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]   id_pc_q, id_pc_d;
   logic [15:0]             count_q, count_d;
   logic                    fire;
   logic                    slot_free;
   logic                    is_halt_word;

   assign fire         = valid_q & id_ready;
   assign slot_free    = ~valid_q | id_ready;
   assign is_halt_word = HALT_ENABLE && (imem_data == HALT_WORD);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      id_pc_d = id_pc_q;
      count_d = count_q;

      // A handshake is counted whatever else happens this cycle, including a redirect.
      if (fire && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end

      if (redirect_valid) begin
         pc_d    = redirect_pc;
         valid_d = 1'b0;
         state_d = StRun;
      end else if (state_q == StHalt) begin
         if (fire) begin
            valid_d = 1'b0;
         end
      end else if (slot_free) begin
         if (is_halt_word) begin
            valid_d = 1'b0;
            state_d = StHalt;
         end else begin
            instr_d = imem_data;
            id_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= '0;
         id_pc_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         id_pc_q <= id_pc_d;
         count_q <= count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign id_valid    = valid_q;
   assign id_instr    = instr_q;
   assign id_pc       = id_pc_q;
   assign halted      = (state_q == StHalt);
   assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a
// rule-level model of the fetch stage and its instruction memory.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] imem_addr, imem_addr1;
   logic [31:0] imem_data, imem_data1;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        id_valid, id_valid1;
   logic        id_ready = 1'b0;
   logic [31:0] id_instr, id_instr1;
   logic [15:0] id_pc, id_pc1;
   logic        halted, halted1;
   logic [15:0] fetch_count, fetch_count1;

   logic [31:0] mem [0:65535];

   int n_vec = 0;
   int n_err = 0;

   // Reference model state (halt word is 0, halting enabled)
   logic [15:0] m_pc;
   logic        m_valid;
   logic [31:0] m_instr;
   logic [15:0] m_idpc;
   logic        m_halt;
   logic [15:0] m_cnt;

   always #5 clk = ~clk;

   assign imem_data  = mem[imem_addr];
   assign imem_data1 = mem[imem_addr1];

   fetch_stage dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
      .halted(halted), .fetch_count(fetch_count)
   );

   fetch_stage #(.HALT_ENABLE(1'b0)) dut_nohalt (
      .clk(clk), .rst(rst), .imem_addr(imem_addr1), .imem_data(imem_data1),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid1), .id_ready(id_ready), .id_instr(id_instr1), .id_pc(id_pc1),
      .halted(halted1), .fetch_count(fetch_count1)
   );

   task automatic model_reset();
      m_pc = 16'h0; m_valid = 1'b0; m_instr = '0; m_idpc = '0; m_halt = 1'b0; m_cnt = '0;
   endtask

   // Apply one rising edge with the given inputs; the model follows the stage's rules.
   task automatic apply(input logic rv, input logic [15:0] rpc, input logic rdy);
      logic took;
      redirect_valid = rv;
      redirect_pc    = rpc;
      id_ready       = rdy;
      took = m_valid && rdy;
      if (took && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (rv) begin
         m_pc = rpc; m_valid = 1'b0; m_halt = 1'b0;
      end else if (m_halt) begin
         if (took) m_valid = 1'b0;
      end else if (!m_valid || rdy) begin
         if (mem[m_pc] == 32'h0) begin
            m_valid = 1'b0; m_halt = 1'b1;
         end else begin
            m_instr = mem[m_pc]; m_idpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 16'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      id_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic load_program();
      for (int i = 0; i < 5; i++) mem[i] = 32'(i + 1);
      mem[5] = 32'h0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({id_valid, id_instr, id_pc, halted, fetch_count, imem_addr} !==
          {1'b0, 32'h0, 16'h0, 1'b0, 16'h0, 16'h0}) begin
         n_err++;
         $display("FAIL reset: got v=%b i=%h p=%h h=%b c=%0d a=%h, want all zero",
                  id_valid, id_instr, id_pc, halted, fetch_count, imem_addr);
      end
   endtask

   task automatic test_sequential();
      load_program();
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         apply(1'b0, 16'h0, 1'b1);
         n_vec++;
         if ({id_valid, id_instr, id_pc, halted} !== {1'b1, 32'(k), 16'(k - 1), 1'b0}) begin
            n_err++;
            $display("FAIL seq_%0d: got v=%b i=%h p=%h h=%b, want v=1 i=%h p=%h h=0",
                     k, id_valid, id_instr, id_pc, halted, 32'(k), 16'(k - 1));
         end
      end
      apply(1'b0, 16'h0, 1'b1);
      n_vec++;
      if ({id_valid, halted, fetch_count, imem_addr} !== {1'b0, 1'b1, 16'd5, 16'd5}) begin
         n_err++;
         $display("FAIL seq_halt: got v=%b h=%b c=%0d a=%h, want v=0 h=1 c=5 a=0005",
                  id_valid, halted, fetch_count, imem_addr);
      end
   endtask

   task automatic test_backpressure();
      load_program();
      do_reset();
      apply(1'b0, 16'h0, 1'b1);
      apply(1'b0, 16'h0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         apply(1'b0, 16'h0, 1'b0);
         n_vec++;
         if ({id_valid, id_instr, id_pc, imem_addr} !== {1'b1, 32'd2, 16'd1, 16'd2}) begin
            n_err++;
            $display("FAIL stall_%0d: got v=%b i=%h p=%h a=%h, want v=1 i=2 p=1 a=2",
                     k, id_valid, id_instr, id_pc, imem_addr);
         end
      end
      apply(1'b0, 16'h0, 1'b1);
      n_vec++;
      if ({id_instr, id_pc, fetch_count} !== {32'd3, 16'd2, 16'd2}) begin
         n_err++;
         $display("FAIL stall_release: got i=%h p=%h c=%0d, want i=3 p=2 c=2",
                  id_instr, id_pc, fetch_count);
      end
   endtask

   task automatic test_redirect_stall();
      load_program();
      mem[16] = 32'hAAAA_0001;
      mem[17] = 32'hBBBB_0002;
      do_reset();
      apply(1'b0, 16'h0, 1'b1);
      apply(1'b1, 16'h0010, 1'b0);
      n_vec++;
      if ({id_valid, imem_addr, fetch_count} !== {1'b0, 16'h0010, 16'd0}) begin
         n_err++;
         $display("FAIL redirect_flush: got v=%b a=%h c=%0d, want v=0 a=0010 c=0",
                  id_valid, imem_addr, fetch_count);
      end
      apply(1'b0, 16'h0, 1'b0);
      n_vec++;
      if ({id_valid, id_pc, id_instr} !== {1'b1, 16'h0010, 32'hAAAA_0001}) begin
         n_err++;
         $display("FAIL redirect_target: got v=%b p=%h i=%h, want v=1 p=0010 i=aaaa0001",
                  id_valid, id_pc, id_instr);
      end
   endtask

   task automatic test_halt_exit();
      load_program();
      do_reset();
      for (int k = 0; k < 6; k++) apply(1'b0, 16'h0, 1'b1);
      apply(1'b1, 16'h0002, 1'b1);
      n_vec++;
      if ({halted, id_valid, imem_addr} !== {1'b0, 1'b0, 16'h0002}) begin
         n_err++;
         $display("FAIL halt_exit: got h=%b v=%b a=%h, want h=0 v=0 a=0002",
                  halted, id_valid, imem_addr);
      end
      apply(1'b0, 16'h0, 1'b1);
      n_vec++;
      if ({id_valid, id_instr, id_pc} !== {1'b1, 32'd3, 16'd2}) begin
         n_err++;
         $display("FAIL halt_resume: got v=%b i=%h p=%h, want v=1 i=3 p=2",
                  id_valid, id_instr, id_pc);
      end
   endtask

   task automatic test_wrap_and_reset();
      mem[16'hFFFF] = 32'h1234_5678;
      mem[0] = 32'h1;
      do_reset();
      apply(1'b1, 16'hFFFF, 1'b1);
      apply(1'b0, 16'h0, 1'b1);
      n_vec++;
      if ({id_pc, id_instr} !== {16'hFFFF, 32'h1234_5678}) begin
         n_err++;
         $display("FAIL wrap_top: got p=%h i=%h, want p=ffff i=12345678", id_pc, id_instr);
      end
      apply(1'b0, 16'h0, 1'b1);
      n_vec++;
      if ({id_pc, id_instr} !== {16'h0000, 32'h1}) begin
         n_err++;
         $display("FAIL wrap_zero: got p=%h i=%h, want p=0000 i=1", id_pc, id_instr);
      end
      apply(1'b0, 16'h0, 1'b0);
      do_reset();
      n_vec++;
      if ({id_valid, imem_addr, fetch_count, halted} !== {1'b0, 16'h0, 16'h0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_in_stall: got v=%b a=%h c=%0d h=%b, want v=0 a=0 c=0 h=0",
                  id_valid, imem_addr, fetch_count, halted);
      end
   endtask

   task automatic test_halt_disabled();
      mem[0] = 32'h0;
      mem[1] = 32'h55;
      do_reset();
      apply(1'b0, 16'h0, 1'b1);
      n_vec++;
      if ({id_valid1, id_instr1, id_pc1, halted1} !== {1'b1, 32'h0, 16'h0, 1'b0}) begin
         n_err++;
         $display("FAIL nohalt_zero: got v=%b i=%h p=%h h=%b, want v=1 i=0 p=0 h=0",
                  id_valid1, id_instr1, id_pc1, halted1);
      end
      apply(1'b0, 16'h0, 1'b1);
      n_vec++;
      if ({id_instr1, id_pc1, halted1, fetch_count1} !== {32'h55, 16'h1, 1'b0, 16'd1}) begin
         n_err++;
         $display("FAIL nohalt_next: got i=%h p=%h h=%b c=%0d, want i=55 p=1 h=0 c=1",
                  id_instr1, id_pc1, halted1, fetch_count1);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 48; i++) begin
         mem[i] = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom | 32'h1);
      end
      do_reset();
      for (int k = 0; k < 400; k++) begin
         logic        rv;
         logic [15:0] rpc;
         rv  = ($urandom_range(0, 7) == 0);
         rpc = 16'($urandom_range(0, 40));
         apply(rv, rpc, 1'($urandom_range(0, 3) != 0));
         n_vec++;
         if ({id_valid, id_instr, id_pc, halted, fetch_count, imem_addr} !==
             {m_valid, m_instr, m_idpc, m_halt, m_cnt, m_pc}) begin
            n_err++;
            $display("FAIL random_%0d: got v=%b i=%h p=%h h=%b c=%0d a=%h, want v=%b i=%h p=%h h=%b c=%0d a=%h",
                     k, id_valid, id_instr, id_pc, halted, fetch_count, imem_addr,
                     m_valid, m_instr, m_idpc, m_halt, m_cnt, m_pc);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_stall();
      test_halt_exit();
      test_wrap_and_reset();
      test_halt_disabled();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
